// File: rtl/dii_packetizer_if.sv
// DII flit channel: one flit per valid&ready handshake, with first/last framing marks.
interface dii_channel #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] data;
  logic             first;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (output data, first, last, valid, input ready);
  modport slave  (input data, first, last, valid, output ready);
endinterface

// File: rtl/dii_packetizer.sv
// Transmit-side DII framer: emits DEST, SRC, FLAGS header flits, then passes payload words through.
//   state     | meaning
//   S_IDLE    | waiting for a packet request; req_ready high
//   S_DEST    | presenting latched destination flit (first=1)
//   S_SRC     | presenting own id flit
//   S_FLAGS   | presenting {type,subtype,0..}; last=1 for header-only packets
//   S_PAYLOAD | payload words passed through until the remaining count runs out
module dii_packetizer #(
  parameter int  WIDTH       = 16,
  parameter int  MAX_PAYLOAD = 8,
  localparam int LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_id,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_dest,
  input  logic [1:0]       i_req_type,
  input  logic [3:0]       i_req_subtype,
  input  logic [LW-1:0]    i_req_len,
  input  logic [WIDTH-1:0] i_pay_data,
  input  logic             i_pay_valid,
  output logic             o_pay_ready,
  output logic             o_busy,
  output logic             o_pkt_done,
  dii_channel.master       out
);

  typedef enum logic [2:0] {S_IDLE, S_DEST, S_SRC, S_FLAGS, S_PAYLOAD} state_t;

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PAYLOAD);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dest;
  logic [1:0]       r_type;
  logic [3:0]       r_subtype;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_cnt;
  logic             r_pkt_done;
  logic [WIDTH-1:0] w_flags;
  logic [LW-1:0]    w_len_clamp;
  logic             w_hs;

  assign w_flags     = {r_type, r_subtype, {(WIDTH-6){1'b0}}};
  assign w_len_clamp = (i_req_len > MAX_LEN) ? MAX_LEN : i_req_len;
  assign w_hs        = out.valid & out.ready;
  assign o_busy      = (r_state != S_IDLE);
  assign o_pkt_done  = r_pkt_done;

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_pay_ready = 1'b0;
    out.valid   = 1'b0;
    out.data    = '0;
    out.first   = 1'b0;
    out.last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = S_DEST;
      end
      S_DEST: begin
        out.valid = 1'b1;
        out.data  = r_dest;
        out.first = 1'b1;
        if (out.ready) w_next = S_SRC;
      end
      S_SRC: begin
        out.valid = 1'b1;
        out.data  = i_id;
        if (out.ready) w_next = S_FLAGS;
      end
      S_FLAGS: begin
        out.valid = 1'b1;
        out.data  = w_flags;
        out.last  = (r_len == '0);
        if (out.ready) w_next = (r_len == '0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // Payload is a straight pass-through; the channel's ready backpressures the source.
        out.valid   = i_pay_valid;
        out.data    = i_pay_data;
        out.last    = (r_cnt == LW'(1));
        o_pay_ready = out.ready;
        if (i_pay_valid && out.ready && (r_cnt == LW'(1))) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dest     <= '0;
      r_type     <= '0;
      r_subtype  <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pkt_done <= w_hs & out.last;
      if (r_state == S_IDLE && i_req_valid) begin
        r_dest    <= i_req_dest;
        r_type    <= i_req_type;
        r_subtype <= i_req_subtype;
        r_len     <= w_len_clamp;
      end
      if (r_state == S_FLAGS && out.ready) r_cnt <= r_len;
      else if (r_state == S_PAYLOAD && w_hs) r_cnt <= r_cnt - LW'(1);
    end
  end

endmodule
